// File: rtl/udma_lin_arbiter.sv
// Round-robin arbiter sharing the uDMA L2 read port among the linear TX channels.
// Optional UDMA_LIN_ARB_PRIO_EN: ch_prio_i-flagged channels win over unflagged ones.
module udma_lin_arbiter #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_CH-1:0]        ch_req_i,
  input  logic [N_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [N_CH*2-1:0]      ch_size_i,
  input  logic [N_CH-1:0]        ch_prio_i,
  output logic [N_CH-1:0]        ch_gnt_o,
  output logic [N_CH-1:0]        ch_rvalid_o,
  output logic [31:0]            ch_rdata_o,
  output logic                   l2_req_o,
  output logic [ADDR_W-1:0]      l2_addr_o,
  output logic [1:0]             l2_size_o,
  input  logic                   l2_gnt_i,
  input  logic                   l2_rvalid_i,
  input  logic [31:0]            l2_rdata_i,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int unsigned ID_W  = $clog2(N_CH);
  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]   fifo_q [MAX_OUT];
  logic              err_q;

  logic [N_CH-1:0] cand;
  logic            slot_free, can_issue, found, push, pop;
  logic [ID_W-1:0] winner;

  always_comb begin
    cand = ch_req_i;
`ifdef UDMA_LIN_ARB_PRIO_EN
    if (|(ch_req_i & ch_prio_i)) cand = ch_req_i & ch_prio_i;
`endif
  end

`ifndef UDMA_LIN_ARB_PRIO_EN
  logic unused_prio;
  assign unused_prio = ^ch_prio_i;
`endif

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && cand[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign slot_free = !valid_q || l2_gnt_i;
  // The held request counts as in flight, so register plus FIFO never exceed MAX_OUT.
  assign can_issue = slot_free && ((out_cnt_q + CNT_W'(valid_q)) < MAX_CNT);
  assign push      = valid_q && l2_gnt_i;
  assign pop       = l2_rvalid_i && (out_cnt_q != '0);

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    size_d   = size_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    ch_gnt_o = '0;
    if (can_issue && found && rstn_i) begin
      ch_gnt_o[winner] = 1'b1;
      valid_d  = 1'b1;
      addr_d   = ch_addr_i[winner*ADDR_W +: ADDR_W];
      size_d   = ch_size_i[winner*2 +: 2];
      id_d     = winner;
      rr_ptr_d = (32'(winner) == N_CH - 1) ? '0 : winner + 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
    out_cnt_d = out_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      out_cnt_q <= out_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (l2_rvalid_i && (out_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= id_q;
  end

  always_comb begin
    ch_rvalid_o = '0;
    if (pop) ch_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign ch_rdata_o = l2_rdata_i;
  assign l2_req_o   = valid_q;
  assign l2_addr_o  = addr_q;
  assign l2_size_o  = size_q;
  assign busy_o     = valid_q || (out_cnt_q != '0);
  assign err_o      = err_q;
endmodule

// File: tb/tb_udma_lin_arbiter.sv
// Scoreboard bench for udma_lin_arbiter: directed traffic with a simple in-order L2 responder.
module tb_udma_lin_arbiter;
  localparam int unsigned N_CH = 8, ADDR_W = 32, MAX_OUT = 4;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [N_CH-1:0]        ch_req = '0;
  logic [N_CH*ADDR_W-1:0] ch_addr = '0;
  logic [N_CH*2-1:0]      ch_size = '0;
  logic [N_CH-1:0]        ch_prio = '0;
  logic [N_CH-1:0]        ch_gnt, ch_rvalid;
  logic [31:0]            ch_rdata;
  logic                   l2_req, l2_gnt = 1'b0, l2_rvalid = 1'b0;
  logic [ADDR_W-1:0]      l2_addr;
  logic [1:0]             l2_size;
  logic [31:0]            l2_rdata = '0;
  logic                   busy, err;

  udma_lin_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rstn_i(rstn), .ch_req_i(ch_req), .ch_addr_i(ch_addr), .ch_size_i(ch_size),
    .ch_prio_i(ch_prio), .ch_gnt_o(ch_gnt), .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata),
    .l2_req_o(l2_req), .l2_addr_o(l2_addr), .l2_size_o(l2_size), .l2_gnt_i(l2_gnt),
    .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int unsigned exp_gnt[$], exp_rid[$];
  logic [31:0] exp_rdat[$], l2q[$], ovr[$];
  int resp_budget = 0;
  logic oneshot = 1'b0, spur = 1'b0;
  logic [N_CH-1:0] s_gnt, s_rvalid;
  logic s_l2req, s_busy, s_err;
  logic [31:0] s_addr;
  int gcount = 0;
  int unsigned mk;
  logic [31:0] md;

  function automatic logic [31:0] addr_of(int unsigned k);
    return 32'h1000_0000 + 32'(k) * 32'h40;
  endfunction
  function automatic logic [31:0] data_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_d(int unsigned k, logic [31:0] d);
    exp_gnt.push_back(k);
    exp_rid.push_back(k);
    exp_rdat.push_back(d);
  endtask
  task automatic expect_ch(int unsigned k);
    expect_d(k, data_of(addr_of(k)));
  endtask

  // Monitor: compare every presented grant/response with the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (ch_gnt != '0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(ch_gnt), 64'(0));
        else begin
          mk = exp_gnt.pop_front();
          check("gnt", 64'(ch_gnt), 64'(1) << mk);
        end
      end
      if (ch_rvalid != '0) begin
        if (exp_rid.size() == 0) check("rsp_unexpected", 64'(ch_rvalid), 64'(0));
        else begin
          mk = exp_rid.pop_front();
          md = exp_rdat.pop_front();
          check("rsp_ch", 64'(ch_rvalid), 64'(1) << mk);
          check("rsp_data", 64'(ch_rdata), 64'(md));
        end
      end
    end
  end

  // One cycle: snapshot at negedge, then act as channels and in-order L2 slave.
  task automatic step();
    logic acc;
    logic [31:0] a;
    @(negedge clk);
    s_gnt = ch_gnt; s_rvalid = ch_rvalid; s_l2req = l2_req; s_addr = l2_addr;
    s_busy = busy; s_err = err;
    acc = l2_req & l2_gnt;
    a = l2_addr;
    gcount += $countones(ch_gnt);
    @(posedge clk); #1;
    if (acc) l2q.push_back(a);
    if (oneshot) ch_req &= ~s_gnt;
    if (spur) begin
      l2_rvalid = 1'b1; l2_rdata = 32'hDEAD_BEEF; spur = 1'b0;
    end else if (resp_budget != 0 && l2q.size() > 0) begin
      a = l2q.pop_front();
      l2_rvalid = 1'b1;
      l2_rdata = (ovr.size() > 0) ? ovr.pop_front() : data_of(a);
      if (resp_budget > 0) resp_budget--;
    end else begin
      l2_rvalid = 1'b0; l2_rdata = '0;
    end
  endtask

  task automatic run_grants(int n, string name);
    int c = 0;
    while (gcount < n && c < 200) begin step(); c++; end
    check({name, "_grants"}, 64'(gcount), 64'(n));
  endtask

  task automatic drain(string name);
    int c = 0;
    while ((exp_gnt.size() != 0 || exp_rid.size() != 0 || l2q.size() != 0 || busy) && c < 200) begin
      step(); c++;
    end
    check({name, "_gnt_left"}, 64'(exp_gnt.size()), 64'(0));
    check({name, "_rsp_left"}, 64'(exp_rid.size()), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic apply_reset();
    rstn = 1'b0; resp_budget = 0; spur = 1'b0; l2_rvalid = 1'b0; l2_rdata = '0;
    exp_gnt.delete(); exp_rid.delete(); exp_rdat.delete(); l2q.delete(); ovr.delete();
    @(negedge clk);
    check("rst_gnt", 64'(ch_gnt), 64'(0));
    check("rst_rvalid", 64'(ch_rvalid), 64'(0));
    check("rst_rdata", 64'(ch_rdata), 64'(0));
    check("rst_l2req", 64'(l2_req), 64'(0));
    check("rst_l2addr", 64'(l2_addr), 64'(0));
    check("rst_l2size", 64'(l2_size), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_addr[k*ADDR_W +: ADDR_W] = addr_of(k);
      ch_size[k*2 +: 2] = 2'(k);
    end
    apply_reset();

    // Continuous requesters 0,3,5 with a free L2 port.
    oneshot = 1'b0; l2_gnt = 1'b1; resp_budget = -1; gcount = 0;
    for (int r = 0; r < 2; r++) begin expect_ch(0); expect_ch(3); expect_ch(5); end
    ch_req = 8'b0010_1001;
    step();
    check("t1_l2req_first", 64'(s_l2req), 64'(0));
    step();
    check("t1_l2req_next", 64'(s_l2req), 64'(1));
    check("t1_l2addr", 64'(s_addr), 64'(addr_of(0)));
    run_grants(6, "t1");
    ch_req = '0;
    drain("t1");

    // L2 stall: one grant, request held stable, later requester waits.
    oneshot = 1'b1; l2_gnt = 1'b0; gcount = 0;
    expect_ch(2);
    ch_req[2] = 1'b1;
    step();
    ch_req[3] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      step();
      check("t2_l2req_hold", 64'(s_l2req), 64'(1));
      check("t2_l2addr_hold", 64'(s_addr), 64'(addr_of(2)));
      check("t2_no_gnt", 64'(gcount), 64'(1));
    end
    check("t2_l2size", 64'(l2_size), 64'(2));
    expect_ch(3);
    l2_gnt = 1'b1;
    run_grants(2, "t2");
    drain("t2");

    // Outstanding limit: four accepted, then one response frees one slot.
    apply_reset();
    oneshot = 1'b1; l2_gnt = 1'b1; resp_budget = 0; gcount = 0;
    for (int unsigned k = 0; k < N_CH; k++) expect_ch(k);
    ch_req = '1;
    for (int r = 0; r < 8; r++) step();
    check("t3_grants_cap", 64'(gcount), 64'(4));
    check("t3_gnt_idle", 64'(s_gnt), 64'(0));
    check("t3_busy", 64'(s_busy), 64'(1));
    check("t3_l2_accepts", 64'(l2q.size()), 64'(4));
    resp_budget = 1;
    for (int r = 0; r < 6; r++) step();
    check("t3_one_more", 64'(gcount), 64'(5));
    check("t3_l2_accepts2", 64'(l2q.size()), 64'(4));
    resp_budget = -1;
    run_grants(8, "t3");
    drain("t3");

    // Response routing for ids 1,6,2 plus a push coinciding with a pop.
    apply_reset();
    oneshot = 1'b1; l2_gnt = 1'b1; resp_budget = 0; gcount = 0;
    expect_d(1, 32'hA); ch_req[1] = 1'b1; step();
    expect_d(6, 32'hB); ch_req[6] = 1'b1; step();
    expect_d(2, 32'hC); ch_req[2] = 1'b1; step();
    step();
    check("t4_l2_accepts", 64'(l2q.size()), 64'(3));
    ovr.push_back(32'hA); ovr.push_back(32'hB); ovr.push_back(32'hC); ovr.push_back(32'hD);
    expect_d(4, 32'hD); ch_req[4] = 1'b1; resp_budget = -1;
    drain("t4");
    check("t4_err", 64'(err), 64'(0));

    // Response with nothing outstanding.
    spur = 1'b1;
    step();
    step();
    check("t5_no_rvalid", 64'(s_rvalid), 64'(0));
    check("t5_err_pre", 64'(s_err), 64'(0));
    for (int r = 0; r < 4; r++) begin
      step();
      check("t5_err_sticky", 64'(s_err), 64'(1));
    end

    // Reset mid-traffic: round-robin pointer restarts at channel 0.
    oneshot = 1'b1; resp_budget = 0; gcount = 0;
    expect_ch(3); ch_req[3] = 1'b1; step();
    expect_ch(5); ch_req[5] = 1'b1; step();
    step();
    check("t6_busy_pre", 64'(s_busy), 64'(1));
    ch_req = 8'b0100_0100;
    apply_reset();
    expect_ch(2); expect_ch(6);
    resp_budget = -1; gcount = 0;
    run_grants(2, "t6");
    drain("t6");

    // Priority class vs plain round-robin.
    oneshot = 1'b0; ch_prio = 8'b0100_0000; gcount = 0;
`ifdef UDMA_LIN_ARB_PRIO_EN
    for (int r = 0; r < 4; r++) expect_ch(6);
`else
    for (int r = 0; r < 2; r++) begin expect_ch(1); expect_ch(6); end
`endif
    ch_req = 8'b0100_0010;
    run_grants(4, "t7");
    ch_req = '0;
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
